multiword_add_sequencer: RTL and testbench



---
 rtl/multiword_add_sequencer_pkg.sv | 15 +
 rtl/multiword_add_sequencer_cla.sv | 53 +++++
 rtl/multiword_add_sequencer.sv | 146 ++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
// Package multiword_add_defs: shared definitions for the multi-word add/subtract sequencer.
//   - state encoding of the sequencer FSM
//   - default slice width and slice count
package multiword_add_defs;

  localparam int DEF_WORD_W    = 16;
  localparam int DEF_NUM_WORDS = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/multiword_add_sequencer_cla.sv
// cla_slice_adder: purely combinational WORD_W-bit carry-lookahead adder.
// It is built from 4-bit lookahead groups. A lookahead carry unit combines the
// group generate/propagate terms to form the carry into each group.
// Ports:
//   a, b    : WORD_W-bit addends
//   cin     : carry into bit 0
//   sum     : WORD_W-bit sum
//   cout    : carry out of the MSB
//   msb_cin : carry into the MSB, which the overflow flag needs
module cla_slice_adder #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              msb_cin
);

  localparam int NG = WORD_W / 4;

  always_comb begin
    logic       gc;
    logic       gp;
    logic       gg;
    logic [3:0] p4;
    logic [3:0] g4;
    logic [3:0] bc;
    sum     = '0;
    msb_cin = 1'b0;
    gc      = cin;
    for (int k = 0; k < NG; k++) begin
      p4 = a[4*k +: 4] ^ b[4*k +: 4];
      g4 = a[4*k +: 4] & b[4*k +: 4];
      // Bit carries inside the 4-bit group, each formed directly from the group carry-in.
      bc[0] = gc;
      bc[1] = g4[0] | (p4[0] & gc);
      bc[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & gc);
      bc[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
            | (p4[2] & p4[1] & p4[0] & gc);
      sum[4*k +: 4] = p4 ^ bc;
      gp = &p4;
      gg = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]);
      if (k == NG - 1) msb_cin = bc[3];
      // Lookahead carry unit: carry into the next group.
      gc = gg | (gp & gc);
    end
    cout = gc;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: performs a WORD_W*NUM_WORDS-bit add or subtract.
// One WORD_W-bit CLA slice is reused once per cycle, starting with the least
// significant slice. The carry between slices passes through a register.
// Optional build macro MULTIWORD_ADD_FLAGS_EN adds the zero, neg and ovf result flags.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   start_valid, start_ready : request handshake; a, b, sub and c_in are sampled on accept
//   a, b                     : W-bit operands
//   sub                      : 1 selects A-B, 0 selects A+B
//   c_in                     : carry-in for an add; ignored for a subtract
//   sum, c_out               : result register and final carry (for sub, 1 = no borrow)
//   busy, done               : busy is high in RUN and DONE; done is a one-cycle result-valid pulse
//   zero, neg, ovf           : result flags, present only with MULTIWORD_ADD_FLAGS_EN
module multiword_add_sequencer
  import multiword_add_defs::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   a,
  input  logic [WORD_W*NUM_WORDS-1:0]   b,
  input  logic                          sub,
  input  logic                          c_in,
  output logic [WORD_W*NUM_WORDS-1:0]   sum,
  output logic                          c_out,
  output logic                          busy,
  output logic                          done
`ifdef MULTIWORD_ADD_FLAGS_EN
  ,
  output logic                          zero,
  output logic                          neg,
  output logic                          ovf
`endif
);

  localparam int W     = WORD_W * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t             state;
  state_t             state_next;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  a_slice;
  logic [WORD_W-1:0]  b_slice;
  logic [WORD_W-1:0]  slice_sum;
  logic               slice_cout;
  logic               msb_cin;
  logic [W-1:0]       sum_next;
  logic               accept;
  logic               last_slice;

  assign accept     = (state == ST_IDLE) && start_valid;
  assign last_slice = (idx == IDX_W'(NUM_WORDS - 1));

  always_comb begin
    a_slice  = '0;
    b_slice  = '0;
    sum_next = sum;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_slice                    = a_reg[i*WORD_W +: WORD_W];
        b_slice                    = b_reg[i*WORD_W +: WORD_W];
        sum_next[i*WORD_W +: WORD_W] = slice_sum;
      end
    end
  end

  cla_slice_adder #(.WORD_W(WORD_W)) u_slice (
    .a       (a_slice),
    .b       (b_slice),
    .cin     (carry),
    .sum     (slice_sum),
    .cout    (slice_cout),
    .msb_cin (msb_cin)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_valid) state_next = ST_RUN;
      ST_RUN:  if (last_slice)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic. rst_n gates start_ready so that a request is never shown as accepted during reset.
  always_comb begin
    start_ready = rst_n && (state == ST_IDLE);
    busy        = (state == ST_RUN) || (state == ST_DONE);
    done        = (state == ST_DONE);
  end

  // Datapath. A subtract is formed as A + ~B + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub ? 1'b1 : c_in;
      idx   <= '0;
    end else if (state == ST_RUN) begin
      sum   <= sum_next;
      carry <= slice_cout;
      if (last_slice) c_out <= slice_cout;
      else            idx   <= idx + 1'b1;
    end
  end

`ifdef MULTIWORD_ADD_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if ((state == ST_RUN) && last_slice) begin
      zero <= (sum_next == '0);
      neg  <= slice_sum[WORD_W-1];
      ovf  <= msb_cin ^ slice_cout;
    end
  end
`else
  logic unused_msb_cin;
  assign unused_msb_cin = msb_cin;
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;
  import multiword_add_defs::*;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 4;
  localparam int W         = WORD_W * NUM_WORDS;
  localparam int TMO       = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         c_in = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
  logic         done;
`ifdef MULTIWORD_ADD_FLAGS_EN
  logic         zero;
  logic         neg;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .c_in        (c_in),
    .sum         (sum),
    .c_out       (c_out),
    .busy        (busy),
    .done        (done)
`ifdef MULTIWORD_ADD_FLAGS_EN
    ,
    .zero        (zero),
    .neg         (neg),
    .ovf         (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: the full-width result {carry, sum} as a W+1-bit number.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s, input logic c);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Signed overflow: both operands are sign-extended by one bit, and the top two result bits disagree.
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic s, input logic c);
    logic [W-1:0] yy;
    logic [W:0]   r;
    yy = s ? ~y : y;
    r  = {x[W-1], x} + {yy[W-1], yy} + {{W{1'b0}}, (s ? 1'b1 : c)};
    return r[W] ^ r[W-1];
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < TMO) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                        input logic tc, input logic [W-1:0] es, input logic ec, input string nm);
    int cyc;
    cyc = 0;
    while (!start_ready && cyc < TMO) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_ready"}, (W+1)'(start_ready), (W+1)'(1));
    a = ta; b = tb; sub = ts; c_in = tc; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    // Operand changes after accept must not matter.
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = ~ts; c_in = ~tc;
    wait_done(cyc);
    chk({nm, "_latency"}, (W+1)'(cyc), (W+1)'(NUM_WORDS));
    chk({nm, "_result"}, {c_out, sum}, {ec, es});
`ifdef MULTIWORD_ADD_FLAGS_EN
    chk({nm, "_flags"}, (W+1)'({zero, neg, ovf}),
        (W+1)'({es == '0, es[W-1], model_ovf(ta, tb, ts, tc)}));
`endif
    @(posedge clk); #1;
    chk({nm, "_pulse"}, (W+1)'({done, start_ready, busy}), (W+1)'(3'b010));
    chk({nm, "_hold"}, {c_out, sum}, {ec, es});
  endtask

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra, rb;
    logic         rs, rc;
    int           cyc, low, npulse;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1};
    vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[4] = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0};
    vecs[6] = '{64'h1, 64'h1, 1'b1, 1'b0, 64'h0, 1'b1};

    // Reset state
    #12;
    chk("rst_outs", (W+1)'({start_ready, busy, done, c_out}), (W+1)'(0));
    chk("rst_sum", (W+1)'(sum), (W+1)'(0));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", (W+1)'(start_ready), (W+1)'(1));

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vcin, vecs[i].esum, vecs[i].ecout,
             $sformatf("vec%0d", i));

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 5 == 0) ra = '1;
      if (i % 7 == 0) rb = ~ra;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      r  = model(ra, rb, rs, rc);
      run_op(ra, rb, rs, rc, r[W-1:0], r[W], $sformatf("rnd%0d", i));
    end

    // Handshake: start_valid held high while operands change every cycle
    ra = 64'h1234_5678_9ABC_DEF0; rb = 64'h0FED_CBA9_8765_4321;
    a = ra; b = rb; sub = 1'b0; c_in = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    low = 0; npulse = 0; cyc = 0;
    while (!start_ready && cyc < TMO) begin
      low++;
      if (done) begin
        npulse++;
        chk("hs_result", {c_out, sum}, model(ra, rb, 1'b0, 1'b1));
      end
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = ~sub;
      @(posedge clk); #1;
      cyc++;
    end
    chk("hs_ready_low", (W+1)'(low), (W+1)'(NUM_WORDS + 1));
    chk("hs_done_pulses", (W+1)'(npulse), (W+1)'(1));
    ra = 64'hAAAA_0000_5555_FFFF; rb = 64'h0000_0001_0000_0001;
    a = ra; b = rb; sub = 1'b1; c_in = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("hs_second_accept", (W+1)'({busy, start_ready}), (W+1)'(2'b10));
    wait_done(cyc);
    chk("hs_second_result", {c_out, sum}, model(ra, rb, 1'b1, 1'b0));
    @(posedge clk); #1;

    // Reset in the second RUN cycle
    a = 64'h0000_0000_0000_FFFF; b = 64'h1; sub = 1'b0; c_in = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", (W+1)'(busy), (W+1)'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", (W+1)'({busy, done, c_out, start_ready}), (W+1)'(0));
    chk("mid_rst_sum", (W+1)'(sum), (W+1)'(0));
    npulse = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) npulse++;
      if (i == 0) chk("mid_release_ready", (W+1)'({start_ready, busy}), (W+1)'(2'b10));
    end
    chk("mid_no_done", (W+1)'(npulse), (W+1)'(0));
    chk("mid_sum_clear", {c_out, sum}, (W+1)'(0));

    run_op(64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
